// File: rtl/tape_pkg.sv
// Shared definitions for the cassette playback source.
//   tape_state_t : transport FSM states
//   HALF1_4MHZ   : half-period of a '1' cell at 4 MHz (1200 Hz)
//   HALF0_4MHZ   : half-period of a '0' cell at 4 MHz (600 Hz)
package tape_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEADER,
    START,
    DATA,
    STOP
  } tape_state_t;

  localparam int unsigned HALF1_4MHZ = 1667;
  localparam int unsigned HALF0_4MHZ = 3333;

endpackage

// File: rtl/tape_fifo.sv
// Synchronous byte FIFO buffering tape image data ahead of the serialiser.
//   clk, reset : clock, synchronous active-high reset
//   flush      : empties the FIFO next cycle, overriding push/pop
//   push, din  : write request and byte (accepted only when din_ready)
//   pop, dout  : read request and head byte (dout valid while level != 0)
//   level      : occupancy, 0 .. 2**FIFO_AW
//   din_ready  : registered "not full"
module tape_fifo #(
  parameter int unsigned FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  output logic [FIFO_AW:0]   level,
  output logic               din_ready
);

  localparam int unsigned      DEPTH = 2**FIFO_AW;
  localparam logic [FIFO_AW:0] FULL  = (FIFO_AW+1)'(DEPTH);

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   level_next;
  logic               do_push;
  logic               do_pop;

  assign do_push = push && din_ready;
  assign do_pop  = pop && (level != '0);
  assign dout    = mem[rd_ptr];

  always_comb begin
    level_next = level;
    if (flush) begin
      level_next = '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10:   level_next = level + 1'b1;
        2'b01:   level_next = level - 1'b1;
        default: level_next = level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      din_ready <= 1'b1;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      din_ready <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level     <= level_next;
      // Computed from the next level so din_ready always matches level.
      din_ready <= (level_next != FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tape_player.sv
// Cassette playback source: buffers tape bytes and plays them out as
// FSK square-wave cells (start '0', 8 data bits LSB first, stop '1's).
//   clk       : cpu_clock
//   reset     : synchronous, active-high
//   play      : transport run level
//   flush     : empties the FIFO (byte in flight still completes)
//   din       : tape byte, din_valid/din_ready handshake
//   cass_out  : modulated tape signal
//   busy      : FSM not idle
//   underrun  : sticky, FIFO was empty at a byte boundary while playing
//   level     : FIFO occupancy
module tape_player
  import tape_pkg::*;
#(
  parameter int unsigned HALF1       = HALF1_4MHZ,
  parameter int unsigned HALF0       = HALF0_4MHZ,
  parameter int unsigned FIFO_AW     = 4,
  parameter int unsigned LEADER_BITS = 256,
  parameter int unsigned STOP_BITS   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             play,
  input  logic             flush,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             cass_out,
  output logic             busy,
  output logic             underrun,
  output logic [FIFO_AW:0] level
);

  localparam int unsigned TW      = $clog2(HALF0) + 1;
  localparam int unsigned CNT_MAX = (LEADER_BITS > 8) ? LEADER_BITS : 8;
  localparam int unsigned CW      = $clog2(((STOP_BITS > CNT_MAX) ? STOP_BITS : CNT_MAX) + 1);
  localparam logic [TW-1:0] H1_LAST = TW'(HALF1 - 1);
  localparam logic [TW-1:0] H0_LAST = TW'(HALF0 - 1);

  tape_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] timer, timer_n;
  logic          phase, phase_n;     // 0 = high half, 1 = low half
  logic          cur_bit, bit_n;     // value of the cell being emitted
  logic [7:0]    shreg, shreg_n;
  logic          cass_n;
  logic          play_d;
  logic          pop;
  logic          set_underrun;
  logic          half_end;
  logic          start_cell;
  logic          to_idle;
  logic [7:0]    fifo_dout;

  tape_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (din_valid),
    .pop       (pop),
    .din       (din),
    .dout      (fifo_dout),
    .level     (level),
    .din_ready (din_ready)
  );

  assign busy     = (state != IDLE);
  assign half_end = (timer == (cur_bit ? H1_LAST : H0_LAST));

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    timer_n      = timer + TW'(1);
    phase_n      = phase;
    bit_n        = cur_bit;
    shreg_n      = shreg;
    cass_n       = cass_out;
    pop          = 1'b0;
    set_underrun = 1'b0;
    start_cell   = 1'b0;
    to_idle      = 1'b0;

    if (state == IDLE) begin
      timer_n = '0;
      phase_n = 1'b0;
      cass_n  = 1'b0;
      if (play) begin
        state_n = LEADER;
        cnt_n   = CW'(LEADER_BITS);
        bit_n   = 1'b1;
        cass_n  = 1'b1;
      end
    end else if (half_end) begin
      timer_n = '0;
      if (!phase) begin
        phase_n = 1'b1;
        cass_n  = 1'b0;
      end else begin
        // Cell boundary: every cell begins high, so the next one starts now.
        phase_n = 1'b0;
        cass_n  = 1'b1;
        unique case (state)
          LEADER: begin
            if (!play)               to_idle    = 1'b1;
            else if (cnt == CW'(1))  start_cell = 1'b1;
            else                     cnt_n      = cnt - 1'b1;
          end
          START: begin
            if (!cur_bit) begin
              state_n = DATA;
              cnt_n   = CW'(8);
              bit_n   = shreg[0];
            end else if (!play) begin
              to_idle = 1'b1;
            end else begin
              start_cell = 1'b1;
            end
          end
          DATA: begin
            shreg_n = shreg >> 1;
            if (cnt == CW'(1)) begin
              state_n = STOP;
              cnt_n   = CW'(STOP_BITS);
              bit_n   = 1'b1;
            end else begin
              cnt_n = cnt - 1'b1;
              bit_n = shreg[1];
            end
          end
          STOP: begin
            if (cnt > CW'(1)) cnt_n      = cnt - 1'b1;
            else if (play)    start_cell = 1'b1;
            else              to_idle    = 1'b1;
          end
          default: to_idle = 1'b1;
        endcase
      end
    end

    // A START cell either carries a popped byte's start bit or, with the
    // FIFO empty, is a mark cell that retries at the next boundary.
    if (start_cell) begin
      state_n = START;
      if (level != '0) begin
        pop     = 1'b1;
        shreg_n = fifo_dout;
        bit_n   = 1'b0;
      end else begin
        set_underrun = 1'b1;
        bit_n        = 1'b1;
      end
    end

    if (to_idle) begin
      state_n = IDLE;
      cass_n  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      timer    <= '0;
      phase    <= 1'b0;
      cur_bit  <= 1'b0;
      shreg    <= '0;
      cass_out <= 1'b0;
      underrun <= 1'b0;
      play_d   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      timer    <= timer_n;
      phase    <= phase_n;
      cur_bit  <= bit_n;
      shreg    <= shreg_n;
      cass_out <= cass_n;
      play_d   <= play;
      if (set_underrun)         underrun <= 1'b1;
      else if (play && !play_d) underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tape_player.sv
module tb_tape_player;

  logic       clk = 1'b0;
  logic       reset;
  logic       play;
  logic       flush;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       cass_out;
  logic       busy;
  logic       underrun;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  tape_player #(
    .HALF1       (4),
    .HALF0       (8),
    .FIFO_AW     (2),
    .LEADER_BITS (2),
    .STOP_BITS   (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .play      (play),
    .flush     (flush),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .cass_out  (cass_out),
    .busy      (busy),
    .underrun  (underrun),
    .level     (level)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; play = 1'b0; flush = 1'b0; din_valid = 1'b0; din = 8'h00;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    din = b; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
  endtask

  // Counts consecutive samples of cass_out equal to v (bounded).
  task automatic count_run(input logic v, output int n);
    n = 0;
    while (cass_out === v && n < 64) begin
      n++;
      step();
    end
  endtask

  task automatic get_cell(output int hi, output int lo);
    count_run(1'b1, hi);
    count_run(1'b0, lo);
  endtask

  // Decodes n cells: 4/4 -> '1', 8/8 -> '0', anything else counted as bad.
  task automatic rx_cells(input int n, output logic [15:0] bits, output int cycles, output int bad);
    int hi, lo;
    bits = '0; cycles = 0; bad = 0;
    for (int i = 0; i < n; i++) begin
      get_cell(hi, lo);
      cycles += hi + lo;
      if (hi == 4 && lo == 4)      bits[i] = 1'b1;
      else if (hi == 8 && lo == 8) bits[i] = 1'b0;
      else                         bad++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 50; i++) begin
      checks++;
      if (cass_out !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1 || level !== 3'd0 || underrun !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: cass=%b busy=%b rdy=%b level=%0d und=%b want 0 0 1 0 0",
                 i, cass_out, busy, din_ready, level, underrun);
      end
      step();
    end
  endtask

  task automatic test_single_byte();
    int hi, lo, cyc, bad;
    logic [15:0] bits;
    do_reset();
    push_byte(8'hA5);
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level_push: got %0d want 1", level); end
    play = 1'b1;
    step();
    checks++; if (cass_out !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_latency: cass=%b busy=%b want 1 1", cass_out, busy); end
    for (int i = 0; i < 2; i++) begin
      get_cell(hi, lo);
      checks++; if (hi != 4 || lo != 4) begin errors++; $display("FAIL single_leader%0d: hi=%0d lo=%0d want 4 4", i, hi, lo); end
    end
    checks++; if (level !== 3'd0 || underrun !== 1'b0) begin errors++; $display("FAIL single_pop: level=%0d und=%b want 0 0", level, underrun); end
    rx_cells(11, bits, cyc, bad);
    checks++; if (bits !== 16'h074A || bad != 0) begin errors++; $display("FAIL single_frame: bits=%h bad=%0d want 074a 0", bits, bad); end
    checks++; if (cyc != 128) begin errors++; $display("FAIL single_frame_len: got %0d want 128", cyc); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL single_underrun: got %b want 1", underrun); end
    get_cell(hi, lo);
    checks++; if (hi != 4 || lo != 4 || busy !== 1'b1) begin errors++; $display("FAIL single_mark: hi=%0d lo=%0d busy=%b want 4 4 1", hi, lo, busy); end
  endtask

  task automatic test_full_fifo();
    int cyc, bad;
    logic [15:0] bits;
    logic [7:0] expb [3];
    do_reset();
    din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 8'h11 * 8'(i + 1);
      step();
      if (i == 3) begin
        checks++; if (din_ready !== 1'b0 || level !== 3'd4) begin errors++; $display("FAIL full_after4: rdy=%b level=%0d want 0 4", din_ready, level); end
      end
    end
    din_valid = 1'b0;
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_drop5: level=%0d want 4", level); end
    play = 1'b1;
    step();
    repeat (15) step();
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_prepop: level=%0d want 4", level); end
    step();
    checks++; if (level !== 3'd3 || din_ready !== 1'b1) begin errors++; $display("FAIL full_pop1: level=%0d rdy=%b want 3 1", level, din_ready); end
    // 0x11 frame is 144 cycles; next pop lands on the edge after 143 more steps.
    repeat (143) step();
    din = 8'h66; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL full_push_pop: level=%0d want 3", level); end
    rx_cells(11, bits, cyc, bad);
    checks++; if (bits !== {5'd0, 2'b11, 8'h22, 1'b0} || bad != 0 || cyc != 144) begin errors++; $display("FAIL full_byte22: bits=%h bad=%0d cyc=%0d want 0644 0 144", bits, bad, cyc); end
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL full_level_after: level=%0d want 2", level); end
    expb[0] = 8'h33; expb[1] = 8'h44; expb[2] = 8'h66;
    for (int k = 0; k < 3; k++) begin
      rx_cells(11, bits, cyc, bad);
      checks++; if (bits !== {5'd0, 2'b11, expb[k], 1'b0} || bad != 0) begin errors++; $display("FAIL full_order%0d: bits=%h bad=%0d want byte %h", k, bits, bad, expb[k]); end
    end
  endtask

  task automatic test_stop_mid_byte();
    int hi, lo, cyc, bad;
    logic [15:0] bits;
    do_reset();
    push_byte(8'h3C);
    push_byte(8'h81);
    play = 1'b1;
    step();
    get_cell(hi, lo);
    get_cell(hi, lo);
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL stop_pop: level=%0d want 1", level); end
    rx_cells(4, bits, cyc, bad);
    checks++; if (bits !== 16'h0008 || bad != 0) begin errors++; $display("FAIL stop_head: bits=%h bad=%0d want 0008 0", bits, bad); end
    play = 1'b0;
    rx_cells(6, bits, cyc, bad);
    checks++; if (bits !== 16'h0027 || bad != 0) begin errors++; $display("FAIL stop_tail: bits=%h bad=%0d want 0027 0", bits, bad); end
    count_run(1'b1, hi);
    repeat (3) step();
    checks++; if (hi != 4 || busy !== 1'b1) begin errors++; $display("FAIL stop_last: hi=%0d busy=%b want 4 1", hi, busy); end
    step();
    checks++; if (busy !== 1'b0 || cass_out !== 1'b0 || level !== 3'd1 || underrun !== 1'b0) begin errors++; $display("FAIL stop_idle: busy=%b cass=%b level=%0d und=%b want 0 0 1 0", busy, cass_out, level, underrun); end
    repeat (20) step();
    checks++; if (busy !== 1'b0 || cass_out !== 1'b0 || level !== 3'd1) begin errors++; $display("FAIL stop_hold: busy=%b cass=%b level=%0d want 0 0 1", busy, cass_out, level); end
  endtask

  task automatic test_flush_push();
    int hi, lo, cyc, bad;
    logic [15:0] bits;
    do_reset();
    push_byte(8'hF0); push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    play = 1'b1;
    step();
    get_cell(hi, lo);
    get_cell(hi, lo);
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL flush_pre: level=%0d want 3", level); end
    count_run(1'b1, hi);
    flush = 1'b1; din = 8'h77; din_valid = 1'b1;
    step();
    flush = 1'b0; din_valid = 1'b0;
    checks++; if (level !== 3'd0 || din_ready !== 1'b1) begin errors++; $display("FAIL flush_level: level=%0d rdy=%b want 0 1", level, din_ready); end
    count_run(1'b0, lo);
    checks++; if (hi != 8 || lo != 7) begin errors++; $display("FAIL flush_start: hi=%0d lo=%0d want 8 7", hi, lo); end
    rx_cells(10, bits, cyc, bad);
    checks++; if (bits !== {6'd0, 2'b11, 8'hF0} || bad != 0 || cyc != 112) begin errors++; $display("FAIL flush_frame: bits=%h bad=%0d cyc=%0d want 03f0 0 112", bits, bad, cyc); end
    checks++; if (underrun !== 1'b1 || level !== 3'd0) begin errors++; $display("FAIL flush_lost: und=%b level=%0d want 1 0", underrun, level); end
  endtask

  task automatic test_reset_abort();
    do_reset();
    push_byte(8'h5A);
    push_byte(8'hC3);
    play = 1'b1;
    step();
    repeat (40) step();
    checks++; if (busy !== 1'b1 || level !== 3'd1) begin errors++; $display("FAIL abort_pre: busy=%b level=%0d want 1 1", busy, level); end
    reset = 1'b1;
    step();
    checks++; if (cass_out !== 1'b0 || busy !== 1'b0 || level !== 3'd0 || underrun !== 1'b0 || din_ready !== 1'b1) begin errors++; $display("FAIL abort_reset: cass=%b busy=%b level=%0d und=%b rdy=%b want 0 0 0 0 1", cass_out, busy, level, underrun, din_ready); end
    reset = 1'b0; play = 1'b0;
  endtask

  task automatic test_underrun_recovery();
    int hi, lo, cyc, bad;
    logic [15:0] bits;
    do_reset();
    play = 1'b1;
    step();
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL urun_init: got %b want 0", underrun); end
    get_cell(hi, lo);
    get_cell(hi, lo);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL urun_set: got %b want 1", underrun); end
    get_cell(hi, lo);
    checks++; if (hi != 4 || lo != 4) begin errors++; $display("FAIL urun_mark: hi=%0d lo=%0d want 4 4", hi, lo); end
    push_byte(8'h00);
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL urun_push: level=%0d want 1", level); end
    get_cell(hi, lo);
    checks++; if (hi != 3 || lo != 4) begin errors++; $display("FAIL urun_mark2: hi=%0d lo=%0d want 3 4", hi, lo); end
    rx_cells(11, bits, cyc, bad);
    checks++; if (bits !== 16'h0600 || bad != 0 || cyc != 160) begin errors++; $display("FAIL urun_frame: bits=%h bad=%0d cyc=%0d want 0600 0 160", bits, bad, cyc); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL urun_sticky: got %b want 1", underrun); end
    get_cell(hi, lo);
    checks++; if (hi != 4 || lo != 4) begin errors++; $display("FAIL urun_mark3: hi=%0d lo=%0d want 4 4", hi, lo); end
    play = 1'b0;
    repeat (8) step();
    checks++; if (busy !== 1'b0 || cass_out !== 1'b0 || underrun !== 1'b1) begin errors++; $display("FAIL urun_idle: busy=%b cass=%b und=%b want 0 0 1", busy, cass_out, underrun); end
    play = 1'b1;
    step();
    checks++; if (underrun !== 1'b0 || cass_out !== 1'b1) begin errors++; $display("FAIL urun_clear: und=%b cass=%b want 0 1", underrun, cass_out); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_full_fifo();
    test_stop_mid_byte();
    test_flush_push();
    test_reset_abort();
    test_underrun_recovery();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
